// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and default width for the arithmetic library
// Purpose : common types/constants for the bit-serial arithmetic cells.
// Contents: state_t (ST_IDLE, ST_SHIFT, ST_DONE), DEF_WIDTH.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor
// Purpose : d = a - b - bin for single bits, with borrow out.
// Ports   : in_bit1 (a), in_bit2 (b), in_borrow (bin) -> out_diff, out_borrow.
module full_subtractor (
  input  logic in_bit1,
  input  logic in_bit2,
  input  logic in_borrow,
  output logic out_diff,
  output logic out_borrow
);

  logic w_xor;

  assign w_xor      = in_bit1 ^ in_bit2;
  assign out_diff   = w_xor ^ in_borrow;
  // Borrow when b > a outright, or when a == b and a borrow is pending.
  assign out_borrow = (~in_bit1 & in_bit2) | (~w_xor & in_borrow);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial minuend - subtrahend - borrow, LSB first
// Purpose : computes A - B - bin mod 2^WIDTH one bit per clock through a single
//           full_subtractor cell and a borrow flip-flop.
// Ports   : in_clk, in_rst (sync, active-high), in_start, in_minuend,
//           in_subtrahend, in_borrow -> out_busy, out_done (1-cycle pulse),
//           out_difference, out_borrow (held until the next operation shifts).
module serial_subtractor #(
  parameter int unsigned WIDTH = arith_pkg::DEF_WIDTH
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_minuend,
  input  logic [WIDTH-1:0] in_subtrahend,
  input  logic             in_borrow,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_difference,
  output logic             out_borrow
);

  import arith_pkg::*;

  // Holds 0..WIDTH; sized so that WIDTH=1 still gets a 1-bit counter.
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_accept;
  logic             w_shift;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_diff_next;

  full_subtractor u_cell (
    .in_bit1    (r_a[0]),
    .in_bit2    (r_b[0]),
    .in_borrow  (r_br),
    .out_diff   (w_d),
    .out_borrow (w_bo)
  );

  // New bit enters at the MSB so that after WIDTH shifts the LSB-first
  // stream lines up with bit positions.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_diff_next = w_d;
    end else begin : g_wn
      assign w_diff_next = {w_d, r_diff[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_shift  = 1'b0;
    out_busy = 1'b0;
    out_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_start) begin
          w_accept = 1'b1;
          w_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        out_busy = 1'b1;
        w_shift  = 1'b1;
        if (r_count == LAST) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_busy = 1'b1;
        out_done = 1'b1;
        w_next   = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_count <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else if (w_accept) begin
      // Result registers are left alone here so the previous result stays
      // readable until the first shift of this operation.
      r_a     <= in_minuend;
      r_b     <= in_subtrahend;
      r_br    <= in_borrow;
      r_count <= '0;
    end else if (w_shift) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_br    <= w_bo;
      r_count <= r_count + CW'(1);
      r_diff  <= w_diff_next;
      r_bout  <= w_bo;
    end
  end

  assign out_difference = r_diff;
  assign out_borrow     = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8 and WIDTH=1)
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    int         acc;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  logic s1_start = 1'b0;
  logic s1_a = 1'b0;
  logic s1_b = 1'b0;
  logic s1_bin = 1'b0;
  logic s1_busy, s1_done, s1_diff, s1_bout;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_start       (start),
    .in_minuend     (a),
    .in_subtrahend  (b),
    .in_borrow      (bin),
    .out_busy       (busy),
    .out_done       (done),
    .out_difference (diff),
    .out_borrow     (bout)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_start       (s1_start),
    .in_minuend     (s1_a),
    .in_subtrahend  (s1_b),
    .in_borrow      (s1_bin),
    .out_busy       (s1_busy),
    .out_done       (s1_done),
    .out_difference (s1_diff),
    .out_borrow     (s1_bout)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t q1[$];
  exp_t e_m, e_m1;
  bit   cont_mode = 1'b0;
  int   last_done = -1;
  bit   hold_chk = 1'b0;
  logic [7:0] hold_d;
  logic       hold_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // WIDTH=8 monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (hold_chk) begin
      check("hold_diff", 32'(diff), 32'(hold_d));
      check("hold_borrow", 32'(bout), 32'(hold_b));
      hold_chk = 1'b0;
    end
    if (!rst && done) begin
      check("busy_in_done", 32'(busy), 32'd1);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d required no done", cyc);
      end else begin
        e_m = q.pop_front();
        check({e_m.name, " diff"}, 32'(diff), 32'(e_m.d));
        check({e_m.name, " borrow"}, 32'(bout), 32'(e_m.bo));
        // Accept edge to visible done is WIDTH further edges.
        check({e_m.name, " latency"}, 32'(cyc - e_m.acc), 32'(W));
        if (cont_mode && last_done >= 0)
          check({e_m.name, " period"}, 32'(cyc - last_done), 32'(W + 2));
        last_done = cyc;
        hold_d    = e_m.d;
        hold_b    = e_m.bo;
        hold_chk  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s1_done) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL w1_unexpected_done: got done at cycle %0d required no done", cyc);
      end else begin
        e_m1 = q1.pop_front();
        check({e_m1.name, " diff"}, 32'(s1_diff), 32'(e_m1.d[0]));
        check({e_m1.name, " borrow"}, 32'(s1_bout), 32'(e_m1.bo));
        check({e_m1.name, " latency"}, 32'(cyc - e_m1.acc), 32'd1);
      end
    end
  end

  task automatic wait_idle(input bit w1);
    int k = 0;
    @(negedge clk);
    while (((w1 ? s1_busy : busy) !== 1'b0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy for %0d cycles required idle", k);
    end
  endtask

  task automatic op(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                    input logic [7:0] ed, input logic ebo, input string nm, input bit hold);
    exp_t e;
    wait_idle(1'b0);
    a = va;
    b = vb;
    bin = vbin;
    start = 1'b1;
    e.d = ed;
    e.bo = ebo;
    e.acc = cyc + 1;
    e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic op1(input logic va, input logic vb, input logic vbin,
                     input logic ed, input logic ebo, input string nm);
    exp_t e;
    wait_idle(1'b1);
    s1_a = va;
    s1_b = vb;
    s1_bin = vbin;
    s1_start = 1'b1;
    e.d = {7'd0, ed};
    e.bo = ebo;
    e.acc = cyc + 1;
    e.name = nm;
    q1.push_back(e);
    @(posedge clk);
    #1;
    s1_start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || q1.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending required 0", q.size() + q1.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // {a, b, bin} index -> WIDTH=1 difference and borrow out.
  logic [7:0] tt_d  = 8'b1001_0110;
  logic [7:0] tt_bo = 8'b1000_1110;

  initial begin
    logic [8:0] r;
    logic [7:0] ra, rb;
    logic       rbin;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst diff", 32'(diff), 32'd0);
    check("rst borrow", 32'(bout), 32'd0);
    check("rst w1 busy", 32'(s1_busy), 32'd0);
    check("rst w1 diff", 32'(s1_diff), 32'd0);
    check("rst w1 borrow", 32'(s1_bout), 32'd0);

    op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, "5A-23", 1'b0);
    op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "00-01", 1'b0);
    op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, "10-10-1", 1'b0);
    op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "FF-00", 1'b0);
    op(8'h23, 8'h5A, 1'b0, 8'hC9, 1'b1, "23-5A", 1'b0);
    drain();

    // Second start mid-operation must be ignored.
    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "05-03 ign", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a = 8'h99;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // Reset at the fourth edge after accept aborts without a done pulse.
    @(negedge clk);
    a = 8'h5A;
    b = 8'h23;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort borrow", 32'(bout), 32'd0);
    repeat (15) @(negedge clk);
    op(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, "post-rst 80-01-1", 1'b0);
    drain();

    // Start held high: back-to-back random operations.
    cont_mode = 1'b1;
    last_done = -1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      r = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      op(ra, rb, rbin, r[7:0], r[8], "rand", 1'b1);
    end
    @(negedge clk);
    start = 1'b0;
    drain();
    cont_mode = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      op1(idx[2], idx[1], idx[0], tt_d[i], tt_bo[i], $sformatf("w1 %0d", i));
    end
    drain();

    check("queue empty", 32'(q.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
